// File: rtl/ex_issue.sv
// ex_issue: ID/EX pipeline register in front of the ALU.
// Takes one decoded instruction per cycle from decode, resolves both sources
// through the forwarding network, applies the PC/immediate operand select and
// holds a registered op/in1/in2 triple plus destination and store-data side-band.
// Load-use and RAW hazards stall decode (id_ready low) and leave bubbles behind.
//
// Build option:
//   EX_ISSUE_FORWARDING_EN defined   -> full alu_out / MEM / WB bypass; only a
//                                       load still in flight causes a hazard.
//   EX_ISSUE_FORWARDING_EN undefined -> WB bypass only; any producer still in
//                                       EX or MEM is a hazard.

package ex_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } aluop_t;
endpackage

// Per-source operand resolution: bypass select and hazard detect for one rsN.
module ex_issue_src #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic            used,
    input  logic [XLEN-1:0] rf_val,
    input  logic            held_valid,
    input  logic [4:0]      held_rd,
    input  logic            held_is_load,
    input  logic [XLEN-1:0] alu_out,
    input  logic            mem_we,
    input  logic            mem_is_load,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_val,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_val,
    output logic [XLEN-1:0] fwd,
    output logic            hazard
);
    logic is_zero;
    logic held_hit;
    logic mem_hit;
    logic wb_hit;

    assign is_zero  = (rs == 5'd0);
    assign held_hit = held_valid && (held_rd == rs);
    assign mem_hit  = mem_we && (mem_rd == rs);
    assign wb_hit   = wb_we && (wb_rd == rs);

`ifdef EX_ISSUE_FORWARDING_EN
    // Youngest producer wins; a held load has no result yet so it is skipped
    // here and reported as a hazard instead.
    always_comb begin
        fwd = rf_val;
        if (is_zero)
            fwd = '0;
        else if (held_hit && !held_is_load)
            fwd = alu_out;
        else if (mem_hit)
            fwd = mem_val;
        else if (wb_hit)
            fwd = wb_val;
    end

    // Only load data not yet available anywhere forces a stall.
    always_comb begin
        hazard = used && !is_zero &&
                 ((held_hit && held_is_load) || (mem_hit && mem_is_load));
    end
`else
    // Without the EX/MEM bypass these inputs have no consumer.
    logic unused_nofwd;
    assign unused_nofwd = ^{alu_out, mem_val, held_is_load, mem_is_load};

    // Only the writeback value can be bypassed.
    always_comb begin
        fwd = rf_val;
        if (is_zero)
            fwd = '0;
        else if (wb_hit)
            fwd = wb_val;
    end

    // Any producer still in EX or MEM must reach WB before we can issue.
    always_comb begin
        hazard = used && !is_zero && (held_hit || mem_hit);
    end
`endif
endmodule

module ex_issue
    import ex_issue_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // decode side
    input  logic                   id_valid,
    output logic                   id_ready,
    input  aluop_t                 id_op,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             id_rd,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [XLEN-1:0]        id_rs1_val,
    input  logic [XLEN-1:0]        id_rs2_val,
    input  logic [XLEN-1:0]        id_imm,
    input  logic [XLEN-1:0]        id_pc,
    input  logic                   id_use_imm,
    input  logic                   id_use_pc,
    input  logic                   id_is_load,
    // bypass sources
    input  logic [XLEN-1:0]        alu_out,
    input  logic                   mem_we,
    input  logic                   mem_is_load,
    input  logic [4:0]             mem_rd,
    input  logic [XLEN-1:0]        mem_val,
    input  logic                   wb_we,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_val,
    // control
    input  logic                   flush,
    // ALU side
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output aluop_t                 ex_op,
    output logic [XLEN-1:0]        ex_in1,
    output logic [XLEN-1:0]        ex_in2,
    output logic [4:0]             ex_rd,
    output logic                   ex_is_load,
    output logic [XLEN-1:0]        ex_rs2_val,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    localparam int NUM_SRC = 2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_SRC-1:0][4:0]      src_rs;
    logic [NUM_SRC-1:0]           src_used;
    logic [NUM_SRC-1:0][XLEN-1:0] src_rf;
    logic [NUM_SRC-1:0][XLEN-1:0] src_fwd;
    logic [NUM_SRC-1:0]           src_haz;

    logic hazard;
    logic capture;
    logic stall_inc;

    // Source 0 is rs1, source 1 is rs2.
    assign src_rs   = {id_rs2, id_rs1};
    assign src_used = {id_rs2_used, id_rs1_used};
    assign src_rf   = {id_rs2_val, id_rs1_val};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        ex_issue_src #(.XLEN(XLEN)) u_src (
            .rs           (src_rs[g]),
            .used         (src_used[g]),
            .rf_val       (src_rf[g]),
            .held_valid   (ex_valid),
            .held_rd      (ex_rd),
            .held_is_load (ex_is_load),
            .alu_out      (alu_out),
            .mem_we       (mem_we),
            .mem_is_load  (mem_is_load),
            .mem_rd       (mem_rd),
            .mem_val      (mem_val),
            .wb_we        (wb_we),
            .wb_rd        (wb_rd),
            .wb_val       (wb_val),
            .fwd          (src_fwd[g]),
            .hazard       (src_haz[g])
        );
    end

    assign hazard    = |src_haz;
    assign ex_valid  = (state == FULL);
    // Flush outranks everything, including a free downstream slot.
    assign id_ready  = !flush && !hazard && (!ex_valid || ex_ready);
    assign capture   = id_valid && id_ready;
    assign stall_inc = id_valid && hazard && !flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Next state: flush empties, capture fills, a drained slot becomes a bubble.
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (capture)
            state_nxt = FULL;
        else if (state == FULL && ex_ready)
            state_nxt = EMPTY;
    end

    // Operand/side-band register; untouched unless a new instruction is taken,
    // so a stalled FULL slot presents stable values to the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_op      <= ALU_ADD;
            ex_in1     <= '0;
            ex_in2     <= '0;
            ex_rd      <= '0;
            ex_is_load <= 1'b0;
            ex_rs2_val <= '0;
        end else if (capture) begin
            ex_op      <= id_op;
            ex_in1     <= id_use_pc  ? id_pc  : src_fwd[0];
            ex_in2     <= id_use_imm ? id_imm : src_fwd[1];
            ex_rd      <= id_rd;
            ex_is_load <= id_is_load;
            ex_rs2_val <= src_fwd[1];
        end
    end

    // Hazard stall counter, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall_inc && !(&stall_cycles))
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
endmodule

// File: doc/ex_issue.md
# ex_issue

Execute-issue stage: the ID/EX pipeline register that feeds the ALU. It accepts one decoded instruction per cycle from decode over a valid/ready handshake, resolves both source operands through the forwarding network, and applies the PC/immediate operand select. It detects load-use and RAW hazards and inserts bubbles, then presents a registered `op`/`in1`/`in2` triple to the ALU together with destination and store-data side-band.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `STALL_CNT_W`, 16, width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode presents an instruction.
- `id_ready`  out  1  stage accepts this cycle.
- `id_op`  in  aluop_t  ALU operation.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_rs1_used`, `id_rs2_used`  in  1 each  source is actually read.
- `id_rs1_val`, `id_rs2_val`  in  32 each  register-file read data.
- `id_imm`, `id_pc`  in  32 each  immediate, instruction PC.
- `id_use_imm`, `id_use_pc`  in  1 each  select imm for in2, PC for in1.
- `id_is_load`  in  1  instruction is a load.
- `alu_out`  in  32  ALU result of the instruction currently held.
- `mem_we`, `mem_is_load`  in  1 each  MEM-stage write enable, MEM-stage holds a load.
- `mem_rd`  in  5; `mem_val`  in  32  MEM-stage destination and result.
- `wb_we`  in  1; `wb_rd`  in  5; `wb_val`  in  32  writeback port.
- `flush`  in  1  kill held and incoming instruction.
- `ex_valid`  out  1; `ex_ready`  in  1  downstream handshake.
- `ex_op`  out  aluop_t; `ex_in1`, `ex_in2`  out  32 each  ALU operands.
- `ex_rd`  out  5; `ex_is_load`  out  1; `ex_rs2_val`  out  32  store data.
- `stall_cycles`  out  `STALL_CNT_W`  saturating hazard-stall count.

## Operation
- States: EMPTY (`ex_valid=0`) and FULL (`ex_valid=1`). There is no other state.
- Forward value per source `rsN`, in priority order:
  - index 0 -> 0;
  - held match (`ex_valid`, `ex_rd==rsN`, not `ex_is_load`) -> `alu_out`;
  - `mem_we && mem_rd==rsN` -> `mem_val`;
  - `wb_we && wb_rd==rsN` -> `wb_val`;
  - otherwise `id_rsN_val`.
- Hazard applies to a used source `rsN != 0` when either:
  - it matches the held instruction and `ex_is_load`, or
  - it matches `mem_rd` with `mem_we && mem_is_load`.
- `id_ready = !flush && !hazard && (!ex_valid || ex_ready)`.
- Capture (`id_valid && id_ready`):
  - `ex_in1 = id_use_pc ? id_pc : fwd1`;
  - `ex_in2 = id_use_imm ? id_imm : fwd2`;
  - `ex_rs2_val = fwd2`;
  - `op`, `rd`, `is_load` registered; state goes to FULL.
- FULL with `ex_ready` and no capture -> EMPTY; this is the bubble.
- FULL with `!ex_ready` -> all outputs held stable.
- `flush` -> EMPTY next cycle regardless of other inputs; the incoming instruction is dropped.
- `stall_cycles` increments when `id_valid && hazard && !flush`, saturates at all-ones, and never wraps.

## Timing
- Reset values:
  - `ex_valid=0`, `ex_op=ALU_ADD`, `ex_in1=ex_in2=ex_rs2_val=0`, `ex_rd=0`, `ex_is_load=0`, `stall_cycles=0`.
  - `id_ready` is combinational and equals 1 during reset unless `flush` is asserted.
- Latency: one cycle from accepted `id_valid` to `ex_valid`. Throughput is 1/cycle absent hazards.
- Load-use with immediate dependent: 2 bubbles. The load is in EX, then in MEM; the operand is forwarded from WB on the third cycle.
- Reset asserted mid-operation: outputs clear immediately (async); the in-flight instruction is lost.
- Simultaneous `flush` and `ex_ready`: flush wins; no capture occurs.

## Configuration
- `EX_ISSUE_FORWARDING_EN` defined: full forwarding as above.
- Undefined:
  - no `alu_out`/`mem_val` bypass;
  - any used-source match with the held instruction or the MEM stage is a hazard;
  - WB bypass is retained;
  - a dependent ALU-to-ALU pair costs 2 bubbles.

## Test plan
- Independent ADDs at 1/cycle with `ex_ready=1` -> `ex_valid` continuous, `stall_cycles=0`.
- `add x5` (result 7) followed by `add x6,x5,x5` -> second captures `ex_in1=ex_in2=7` from `alu_out` with no bubble. With the macro undefined -> 2 bubbles and `stall_cycles=2`.
- Load `x5` followed by `sub x7,x5,x1` -> two cycles of `id_ready=0`, then `ex_in1=wb_val` (0xDEAD_BEEF), `stall_cycles=2`.
- `ex_ready=0` for 3 cycles while FULL -> all `ex_*` outputs unchanged and `id_ready=0`.
- `flush` while FULL with `id_valid=1` -> next cycle `ex_valid=0` and the incoming instruction never appears.
- `rs1=x0` while MEM writes x0 with 0x55 -> `ex_in1=0` and no hazard.
